keypad_pin_entry: RTL and testbench

- 4x4 matrix keypad scanner and PIN entry front-end that produces the `pin`, `npin`, `enter` and `rst_pin` signals consumed by the lock controller.
- Scans columns, debounces key presses, decodes keys, collects hex digits and issues submit or PIN-change requests.
- Request outputs are held as stretched levels, long enough to pass the lock's own button debouncers.

---
 rtl/keypad_pin_entry_if.sv | 23 ++
 rtl/keypad_pin_entry.sv | 160 ++++++++++++++++
 tb/tb_keypad_pin_entry.sv | 138 +++++++++++++
 3 files changed

// File: rtl/keypad_pin_entry_if.sv
// keypad_pin_entry_if: keypad matrix lines plus the PIN/request signals handed to the lock controller.
interface keypad_pin_entry_if #(parameter int DIGITS = 1);
  localparam int DW = $clog2(DIGITS + 1);
  logic [3:0]          row_n;
  logic [3:0]          col_n;
  logic [4*DIGITS-1:0] pin;
  logic [4*DIGITS-1:0] npin;
  logic                enter;
  logic                rst_pin;
  logic                npin_mode;
  logic [DW-1:0]       digit_cnt;
  logic                key_valid;
  logic [3:0]          key_code;
  logic                key_err;
  modport slave (
    input  row_n,
    output col_n, pin, npin, enter, rst_pin, npin_mode, digit_cnt, key_valid, key_code, key_err
  );
  modport master (
    output row_n,
    input  col_n, pin, npin, enter, rst_pin, npin_mode, digit_cnt, key_valid, key_code, key_err
  );
endinterface

// File: rtl/keypad_pin_entry.sv
// keypad_pin_entry: 4x4 keypad scanner with debounce, hex PIN buffer and stretched enter/rst_pin requests.
module keypad_pin_entry #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int PULSE_CYCLES   = 2097152,
  parameter int DIGITS         = 1
) (
  input logic               clk,
  input logic               rst_n,
  keypad_pin_entry_if.slave kp
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int DW = $clog2(DIGITS + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [DW-1:0] DMAX = DW'(DIGITS);
  // indexed by {row, col}; '*' = E, '#' = F
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hF, 4'h0, 4'hE, 4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4, 4'hA, 4'h3, 4'h2, 4'h1};
  typedef enum logic [1:0] {SCAN, CONFIRM, HELD} state_t;

  logic [3:0]    r_row_s1, r_row_s2;
  logic [SW-1:0] r_div;
  logic [1:0]    r_col;
  logic [1:0]    r_hits;
  logic [3:0]    r_code;
  state_t        r_state;
  logic [CW-1:0] r_db_cnt;
  logic [3:0]    r_key;
  logic [BW-1:0] r_buf, r_pin, r_npin;
  logic [DW-1:0] r_digit_cnt;
  logic          r_npin_mode, r_enter, r_rst_pin, r_key_valid, r_key_err;
  logic [3:0]    r_key_code;
  logic [PW-1:0] r_pulse_cnt;

  logic [3:0] w_low;
  logic [2:0] w_ones;
  logic [1:0] w_row;
  logic [2:0] w_hits_sum;
  logic [1:0] w_hits;
  logic [3:0] w_code;
  logic       w_sample, w_done, w_none, w_single, w_same, w_accept, w_busy;

  assign w_low      = ~r_row_s2;
  assign w_ones     = 3'(w_low[0]) + 3'(w_low[1]) + 3'(w_low[2]) + 3'(w_low[3]);
  assign w_row      = w_low[0] ? 2'd0 : w_low[1] ? 2'd1 : w_low[2] ? 2'd2 : 2'd3;
  assign w_sample   = r_div == SW'(SCAN_DIV - 1);
  assign w_done     = w_sample && r_col == 2'd3;
  // intersection count saturates at 2: anything above one key is MULTI
  assign w_hits_sum = (r_col == 2'd0 ? 3'd0 : {1'b0, r_hits}) + w_ones;
  assign w_hits     = w_hits_sum > 3'd2 ? 2'd2 : w_hits_sum[1:0];
  assign w_code     = w_ones == 3'd1 ? KEYMAP[{w_row, r_col}] : r_code;
  assign w_none     = w_hits == 2'd0;
  assign w_single   = w_hits == 2'd1;
  assign w_same     = w_single && w_code == r_key;
  assign w_accept   = w_done && r_state == CONFIRM && w_same && r_db_cnt == CW'(DEBOUNCE_SCANS - 1);
  assign w_busy     = r_enter | r_rst_pin;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
      r_div    <= '0;
      r_col    <= '0;
      r_hits   <= '0;
      r_code   <= '0;
    end else begin
      r_row_s1 <= kp.row_n;
      r_row_s2 <= r_row_s1;
      r_div    <= w_sample ? '0 : r_div + 1'b1;
      if (w_sample) begin
        r_col  <= r_col + 1'b1;
        r_hits <= w_hits;
        r_code <= w_code;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= SCAN;
      r_db_cnt    <= '0;
      r_key       <= '0;
      r_buf       <= '0;
      r_pin       <= '0;
      r_npin      <= '0;
      r_digit_cnt <= '0;
      r_npin_mode <= 1'b0;
      r_enter     <= 1'b0;
      r_rst_pin   <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
      r_key_code  <= '0;
      r_pulse_cnt <= '0;
    end else begin
      r_key_valid <= w_accept;
      r_key_err   <= 1'b0;
      if (w_busy) begin
        if (r_pulse_cnt == '0) {r_enter, r_rst_pin} <= 2'b00;
        else r_pulse_cnt <= r_pulse_cnt - 1'b1;
      end
      if (w_done)
        case (r_state)
          SCAN: if (w_single) begin
            r_state  <= CONFIRM;
            r_key    <= w_code;
            r_db_cnt <= CW'(1);
          end
          CONFIRM: if (!w_same || w_accept) begin
            r_state  <= w_accept ? HELD : SCAN;
            r_db_cnt <= '0;
          end else r_db_cnt <= r_db_cnt + 1'b1;
          HELD: if (!w_none) r_db_cnt <= '0;
          else if (r_db_cnt == CW'(DEBOUNCE_SCANS - 1)) begin
            r_state  <= SCAN;
            r_db_cnt <= '0;
          end else r_db_cnt <= r_db_cnt + 1'b1;
          default: r_state <= SCAN;
        endcase
      if (w_accept) begin
        r_key_code <= r_key;
        if (r_key == 4'hA) r_npin_mode <= ~r_npin_mode;
        else if (r_key == 4'hE) begin
          r_buf       <= '0;
          r_digit_cnt <= '0;
          r_npin_mode <= 1'b0;
        end else if (r_key == 4'hF) begin
          if (r_digit_cnt != DMAX || w_busy) r_key_err <= 1'b1;
          else begin
            r_buf       <= '0;
            r_digit_cnt <= '0;
            r_pulse_cnt <= PW'(PULSE_CYCLES - 1);
            if (r_npin_mode) begin
              r_npin      <= r_buf;
              r_rst_pin   <= 1'b1;
              r_npin_mode <= 1'b0;
            end else begin
              r_pin   <= r_buf;
              r_enter <= 1'b1;
            end
          end
        end else if (r_digit_cnt != DMAX) begin
          r_buf       <= BW'({r_buf, r_key});
          r_digit_cnt <= r_digit_cnt + 1'b1;
        end
      end
    end

  assign kp.col_n     = ~(4'b0001 << r_col);
  assign kp.pin       = r_pin;
  assign kp.npin      = r_npin;
  assign kp.enter     = r_enter;
  assign kp.rst_pin   = r_rst_pin;
  assign kp.npin_mode = r_npin_mode;
  assign kp.digit_cnt = r_digit_cnt;
  assign kp.key_valid = r_key_valid;
  assign kp.key_code  = r_key_code;
  assign kp.key_err   = r_key_err;
endmodule

// File: tb/tb_keypad_pin_entry.sv
// tb_keypad_pin_entry: directed keypad presses against a resistive-matrix model, hand-computed expectations.
module tb_keypad_pin_entry;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0][3:0] keys = '0;
  int total = 0, bad = 0;
  int nvalid = 0, nerr = 0, en_cyc = 0, rp_cyc = 0, both = 0;
  int v0;
  logic [3:0] last_code = '0;

  keypad_pin_entry_if #(.DIGITS(1)) kp ();
  keypad_pin_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .PULSE_CYCLES(8), .DIGITS(1))
    dut (.clk(clk), .rst_n(rst_n), .kp(kp));

  always #5 clk = ~clk;

  always_comb for (int r = 0; r < 4; r++) kp.row_n[r] = ~|(keys[r] & ~kp.col_n);

  always @(negedge clk)
    if (rst_n) begin
      if (kp.key_valid) begin
        nvalid++;
        last_code = kp.key_code;
      end
      if (kp.key_err) nerr++;
      if (kp.enter) en_cyc++;
      if (kp.rst_pin) rp_cyc++;
      if (kp.enter && kp.rst_pin) both++;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int r, input int c, input int cycles);
    @(negedge clk);
    keys[r][c] = 1'b1;
    repeat (cycles) @(negedge clk);
    keys[r][c] = 1'b0;
  endtask

  task automatic press(input int r, input int c);
    hold(r, c, 64);
    repeat (64) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_col_n", kp.col_n, 4'b1110);
    chk("rst_pin", kp.pin, 0);
    chk("rst_enter", kp.enter, 0);
    chk("rst_digit_cnt", kp.digit_cnt, 0);
    chk("rst_key_code", kp.key_code, 0);
    chk("rst_npin_mode", kp.npin_mode, 0);
    rst_n = 1'b1;
    // D then # : submit D on enter
    press(3, 3);
    chk("d_valid", nvalid, 1);
    chk("d_code", last_code, 4'hD);
    chk("d_digit_cnt", kp.digit_cnt, 1);
    press(3, 2);
    chk("hash_code", last_code, 4'hF);
    chk("enter_pin", kp.pin, 4'hD);
    chk("enter_len", en_cyc, 8);
    chk("enter_digit_cnt", kp.digit_cnt, 0);
    chk("enter_no_err", nerr, 0);
    // A, 7, # : new PIN path
    press(0, 3);
    chk("a_npin_mode", kp.npin_mode, 1);
    press(2, 0);
    chk("seven_digit_cnt", kp.digit_cnt, 1);
    press(3, 2);
    chk("npin_val", kp.npin, 4'h7);
    chk("rst_pin_len", rp_cyc, 8);
    chk("npin_no_enter", en_cyc, 8);
    chk("npin_mode_clr", kp.npin_mode, 0);
    chk("npin_pin_kept", kp.pin, 4'hD);
    // # with empty buffer
    press(3, 2);
    chk("empty_err", nerr, 1);
    chk("empty_no_enter", en_cyc, 8);
    chk("empty_pin_kept", kp.pin, 4'hD);
    // bounce on key 5, then a clean hold
    v0 = nvalid;
    repeat (3) begin
      hold(1, 1, 16);
      repeat (16) @(negedge clk);
    end
    chk("bounce_none", nvalid, v0);
    hold(1, 1, 48);
    repeat (64) @(negedge clk);
    chk("bounce_one", nvalid, v0 + 1);
    chk("bounce_code", last_code, 4'h5);
    chk("bounce_digit_cnt", kp.digit_cnt, 1);
    // 1 and 2 together, then only 1 (digit dropped: buffer full)
    v0 = nvalid;
    @(negedge clk);
    keys[0][0] = 1'b1;
    keys[0][1] = 1'b1;
    repeat (64) @(negedge clk);
    chk("multi_none", nvalid, v0);
    keys[0][1] = 1'b0;
    repeat (64) @(negedge clk);
    keys[0][0] = 1'b0;
    repeat (64) @(negedge clk);
    chk("multi_one", nvalid, v0 + 1);
    chk("multi_code", last_code, 4'h1);
    chk("full_digit_cnt", kp.digit_cnt, 1);
    // # submits 5, reset dropped mid-pulse
    @(negedge clk);
    keys[3][2] = 1'b1;
    for (int i = 0; i < 200 && !kp.enter; i++) @(negedge clk);
    chk("enter_seen", kp.enter, 1);
    chk("pin_at_enter", kp.pin, 4'h5);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_enter", kp.enter, 0);
    chk("mid_rst_pin", kp.pin, 0);
    chk("mid_rst_col_n", kp.col_n, 4'b1110);
    chk("mid_rst_digit_cnt", kp.digit_cnt, 0);
    keys[3][2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = nvalid;
    press(2, 2);
    chk("post_rst_valid", nvalid, v0 + 1);
    chk("post_rst_code", last_code, 4'h9);
    chk("post_rst_digit_cnt", kp.digit_cnt, 1);
    chk("never_both", both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
